// File: rtl/ros2_pub_scheduler_if.sv
// Configuration, command and status bundle between a publish host and ros2_pub_scheduler.
// The host drives configuration and one-cycle command pulses; the scheduler returns registered status.
interface ros2_pub_scheduler_if #(
    parameter int unsigned PERIOD_W     = 32,
    parameter int unsigned COUNT_W      = 8,
    parameter int unsigned NUM_PATTERNS = 2
);

    logic [PERIOD_W-1:0]     cfg_period;
    logic [COUNT_W-1:0]      cfg_max_pubs;
    logic [NUM_PATTERNS-1:0] cfg_pattern_mask;
    logic                    cmd_start;
    logic                    cmd_stop;
    logic                    cmd_restart;
    logic [7:0]              ros2_ctrl;
    logic                    pub_tick;
    logic [COUNT_W-1:0]      pub_count;
    logic                    done;

    modport master (
        output cfg_period,
        output cfg_max_pubs,
        output cfg_pattern_mask,
        output cmd_start,
        output cmd_stop,
        output cmd_restart,
        input  ros2_ctrl,
        input  pub_tick,
        input  pub_count,
        input  done
    );

    modport slave (
        input  cfg_period,
        input  cfg_max_pubs,
        input  cfg_pattern_mask,
        input  cmd_start,
        input  cmd_stop,
        input  cmd_restart,
        output ros2_ctrl,
        output pub_tick,
        output pub_count,
        output done
    );

endinterface

// File: rtl/ros2_pub_scheduler.sv
// Runtime-configurable publish scheduler producing the ros2_ctrl word: rotates through enabled
// payload patterns once per programmable interval and stops after a programmable publish count.
module ros2_pub_scheduler #(
    parameter int unsigned PERIOD_W     = 32,
    parameter int unsigned COUNT_W      = 8,
    parameter int unsigned NUM_PATTERNS = 2,
    parameter int unsigned AUTO_START   = 1
) (
    input logic                 clk_int,
    input logic                 rst_int,
    ros2_pub_scheduler_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam state_e     StReset = (AUTO_START != 0) ? StRun : StIdle;
    localparam logic [6:0] NumPat  = 7'(NUM_PATTERNS);

    state_e              state_q, state_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] last_cnt;
    logic [COUNT_W-1:0]  count_q, count_d;
    logic [COUNT_W-1:0]  count_inc;
    logic [5:0]          idx_q, idx_d;
    logic [5:0]          idx_adv, idx_first;
    logic                tick_q, tick_d;
    logic                en_q, done_q;
    logic                at_last;
    logic                adv_found;
    logic [6:0]          adv_sum;
    logic [63:0]         mask_ext;

    assign mask_ext = 64'(bus.cfg_pattern_mask);

    // A period of 0 behaves as 1, so the terminal count is 0 in both cases.
    assign last_cnt  = (period_q == '0) ? '0 : period_q - PERIOD_W'(1);
    assign at_last   = (cnt_q == last_cnt);
    assign count_inc = (&count_q) ? count_q : count_q + COUNT_W'(1);

    // Next enabled pattern after the current one, wrapping; holds if no other pattern is enabled.
    always_comb begin
        idx_adv   = idx_q;
        adv_found = 1'b0;
        adv_sum   = '0;
        for (int k = 1; k < int'(NUM_PATTERNS); k++) begin
            adv_sum = 7'(idx_q) + 7'(k);
            if (adv_sum >= NumPat) begin
                adv_sum = adv_sum - NumPat;
            end
            if (!adv_found && mask_ext[adv_sum[5:0]]) begin
                adv_found = 1'b1;
                idx_adv   = adv_sum[5:0];
            end
        end
    end

    // Lowest enabled pattern, used on restart; zero when the mask is empty.
    always_comb begin
        idx_first = '0;
        for (int i = int'(NUM_PATTERNS) - 1; i >= 0; i--) begin
            if (mask_ext[6'(i)]) begin
                idx_first = 6'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        count_d  = count_q;
        idx_d    = idx_q;
        tick_d   = 1'b0;

        if (bus.cmd_restart) begin
            state_d  = StRun;
            period_d = bus.cfg_period;
            cnt_d    = '0;
            count_d  = '0;
            idx_d    = idx_first;
        end else if (bus.cmd_stop && (state_q == StRun)) begin
            // A stop on the terminal cycle swallows that tick entirely.
            state_d = StIdle;
        end else if (bus.cmd_start && (state_q != StRun)) begin
            state_d  = StRun;
            period_d = bus.cfg_period;
            cnt_d    = '0;
        end else if (state_q == StRun) begin
            if (at_last) begin
                cnt_d    = '0;
                tick_d   = 1'b1;
                idx_d    = idx_adv;
                count_d  = count_inc;
                period_d = bus.cfg_period;
                // >= so a resumed run whose count already met the limit stops at its next tick.
                if ((bus.cfg_max_pubs != '0) && (count_inc >= bus.cfg_max_pubs)) begin
                    state_d = StDone;
                end
            end else begin
                cnt_d = cnt_q + PERIOD_W'(1);
            end
        end
    end

    always_ff @(posedge clk_int) begin
        if (rst_int) begin
            state_q  <= StReset;
            period_q <= bus.cfg_period;
            cnt_q    <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            tick_q   <= 1'b0;
            en_q     <= (AUTO_START != 0);
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            tick_q   <= tick_d;
            en_q     <= (state_d == StRun);
            done_q   <= (state_d == StDone);
        end
    end

    assign bus.ros2_ctrl = {1'b0, idx_q, en_q};
    assign bus.pub_tick  = tick_q;
    assign bus.pub_count = count_q;
    assign bus.done      = done_q;

endmodule
